// File: rtl/bank_rd_seq.sv
// Read-side sequencer for one bank: turns (base, stride, length) into one read per credit,
// captures 1-cycle-latency read data into a 2-entry buffer and streams it out with a last flag.
module bank_rd_seq #(
    parameter int w = 64,
    parameter int a = 10,
    parameter int l = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [a-1:0] base_addr,
    input  logic [a-1:0] stride,
    input  logic [l-1:0] length,
    input  logic [1:0]   muxcode,
    output logic         busy,
    output logic         done,
    output logic         rd_en,
    output logic [a-1:0] rd_addr,
    output logic [1:0]   rd_muxcode,
    input  logic [w-1:0] rd_word,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [w-1:0] o_data,
    output logic         o_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [l-1:0] CNT_ZERO = {l{1'b0}};
    localparam logic [l-1:0] CNT_ONE  = {{(l-1){1'b0}}, 1'b1};

    state_t       state_r;
    state_t       state_nx_s;
    logic [a-1:0] cur_addr_r;
    logic [a-1:0] stride_r;
    logic [l-1:0] issue_cnt_r;
    logic [1:0]   muxcode_r;
    logic         inflight_r;
    logic         inflight_last_r;
    logic         busy_r;
    logic         done_r;
    logic         o_valid_r;

    logic [1:0]   cnt_r;
    logic [1:0]   cnt_nx_s;
    logic [w-1:0] ent0_data_r;
    logic [w-1:0] ent0_data_nx_s;
    logic         ent0_last_r;
    logic         ent0_last_nx_s;
    logic [w-1:0] ent1_data_r;
    logic [w-1:0] ent1_data_nx_s;
    logic         ent1_last_r;
    logic         ent1_last_nx_s;

    logic         start_acc_s;
    logic         issue_s;
    logic         issue_last_s;
    logic         push_s;
    logic         pop_s;
    logic [2:0]   credit_used_s;

    // Credit accounting: buffered words plus the read still in flight; a handshake
    // frees its credit only from the next cycle on.
    always_comb begin
        credit_used_s = {1'b0, cnt_r} + {2'b00, inflight_r};
        start_acc_s   = (state_r == IDLE) && start;
        issue_s       = (state_r == RUN) && (issue_cnt_r != CNT_ZERO) && (credit_used_s < 3'd2);
        issue_last_s  = issue_s && (issue_cnt_r == CNT_ONE);
        push_s        = inflight_r;
        pop_s         = (cnt_r != 2'd0) && o_ready;
    end

    // Next-state logic of the job FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length == CNT_ZERO) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = RUN;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (issue_last_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && ent0_last_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Next contents of the 2-entry output buffer; entry 0 is always the head.
    always_comb begin
        cnt_nx_s       = cnt_r;
        ent0_data_nx_s = ent0_data_r;
        ent0_last_nx_s = ent0_last_r;
        ent1_data_nx_s = ent1_data_r;
        ent1_last_nx_s = ent1_last_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_r == 2'd0) begin
                    ent0_data_nx_s = rd_word;
                    ent0_last_nx_s = inflight_last_r;
                    cnt_nx_s       = 2'd1;
                end else begin
                    ent1_data_nx_s = rd_word;
                    ent1_last_nx_s = inflight_last_r;
                    cnt_nx_s       = 2'd2;
                end
            end
            2'b01: begin
                ent0_data_nx_s = ent1_data_r;
                ent0_last_nx_s = ent1_last_r;
                cnt_nx_s       = cnt_r - 2'd1;
            end
            2'b11: begin
                if (cnt_r == 2'd1) begin
                    ent0_data_nx_s = rd_word;
                    ent0_last_nx_s = inflight_last_r;
                end else begin
                    ent0_data_nx_s = ent1_data_r;
                    ent0_last_nx_s = ent1_last_r;
                    ent1_data_nx_s = rd_word;
                    ent1_last_nx_s = inflight_last_r;
                end
            end
            default: cnt_nx_s = cnt_r;
        endcase
    end

    // FSM state, job registers and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            cur_addr_r      <= {a{1'b0}};
            stride_r        <= {a{1'b0}};
            issue_cnt_r     <= CNT_ZERO;
            muxcode_r       <= 2'b00;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            inflight_r      <= issue_s;
            inflight_last_r <= issue_last_s;
            busy_r          <= (state_nx_s != IDLE);
            done_r          <= (state_nx_s == DONE);
            if (start_acc_s) begin
                cur_addr_r  <= base_addr;
                stride_r    <= stride;
                issue_cnt_r <= length;
                muxcode_r   <= muxcode;
            end else if (issue_s) begin
                cur_addr_r  <= cur_addr_r + stride_r;
                issue_cnt_r <= issue_cnt_r - CNT_ONE;
            end else begin
                cur_addr_r  <= cur_addr_r;
                issue_cnt_r <= issue_cnt_r;
            end
        end
    end

    // Output buffer storage; o_valid is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 2'd0;
            ent0_data_r <= {w{1'b0}};
            ent0_last_r <= 1'b0;
            ent1_data_r <= {w{1'b0}};
            ent1_last_r <= 1'b0;
            o_valid_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nx_s;
            ent0_data_r <= ent0_data_nx_s;
            ent0_last_r <= ent0_last_nx_s;
            ent1_data_r <= ent1_data_nx_s;
            ent1_last_r <= ent1_last_nx_s;
            o_valid_r   <= (cnt_nx_s != 2'd0);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_en      = issue_s;
    assign rd_addr    = cur_addr_r;
    assign rd_muxcode = muxcode_r;
    assign o_valid    = o_valid_r;
    assign o_data     = ent0_data_r;
    assign o_last     = ent0_last_r;

endmodule
